// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: diff = a - b - bin over WIDTH bits, DIGIT bits per clock,
// with a registered borrow chain, valid/ready handshakes, unsigned borrow and signed overflow flags.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             busy
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if ((WIDTH < 2) || (DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
      $error("serial_subtractor: WIDTH must be >= 2 and a multiple of DIGIT, 1 <= DIGIT <= WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               borrow_q, borrow_d;
  logic               bout_q, bout_d;
  logic               ovf_q, ovf_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [DIGIT:0]     sub_s;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (cnt_q == LAST) begin
          state_d = DONE;
        end else begin
          state_d = CALC;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state register only
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      CALC:    busy      = 1'b1;
      DONE:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // One digit slice: low DIGIT bits of each operand minus the carried borrow
  always_comb begin
    sub_s = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]} - {{DIGIT{1'b0}}, borrow_q};
  end

  // Datapath next-state: operand latch, slice accumulation, result publish on the last step
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          res_d    = '0;
          cnt_d    = '0;
        end else begin
          cnt_d    = cnt_q;
        end
      end
      CALC: begin
        res_d[int'(cnt_q)*DIGIT +: DIGIT] = sub_s[DIGIT-1:0];
        a_d      = a_q >> DIGIT;
        b_d      = b_q >> DIGIT;
        borrow_d = sub_s[DIGIT];
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // The MSB's borrow-in is recoverable as a ^ b ^ diff at that bit.
          diff_d = res_d;
          bout_d = sub_s[DIGIT];
          ovf_d  = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ sub_s[DIGIT-1] ^ sub_s[DIGIT];
        end else begin
          diff_d = diff_q;
        end
      end
      DONE: begin
        cnt_d = cnt_q;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor across seven WIDTH/DIGIT configurations run in lockstep.
module tb_serial_subtractor;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic        bin;
  logic [15:0] a_in;
  logic [15:0] b_in;

  wire  [6:0]  in_ready_v;
  wire  [6:0]  out_valid_v;
  wire  [6:0]  bout_v;
  wire  [6:0]  ovf_v;
  wire  [6:0]  busy_v;
  wire  [7:0]  d0, d1, d2, d3;
  wire  [15:0] d4, d5, d6;
  logic [15:0] diff_v [7];

  int checks = 0;
  int fails  = 0;

  const int WID [7] = '{8, 8, 8, 8, 16, 16, 16};
  const int NST [7] = '{8, 4, 2, 1, 16, 8, 4};

  logic [15:0] cur_a, cur_b;
  logic        cur_bin;
  logic [15:0] cap_diff [7];
  logic        cap_bout [7];
  logic        cap_ovf  [7];

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_8d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[0]),
    .a(a_in[7:0]), .b(b_in[7:0]), .bin(bin), .out_valid(out_valid_v[0]), .out_ready(out_ready),
    .diff(d0), .bout(bout_v[0]), .ovf(ovf_v[0]), .busy(busy_v[0]));
  serial_subtractor #(.WIDTH(8), .DIGIT(2)) u_8d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[1]),
    .a(a_in[7:0]), .b(b_in[7:0]), .bin(bin), .out_valid(out_valid_v[1]), .out_ready(out_ready),
    .diff(d1), .bout(bout_v[1]), .ovf(ovf_v[1]), .busy(busy_v[1]));
  serial_subtractor #(.WIDTH(8), .DIGIT(4)) u_8d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[2]),
    .a(a_in[7:0]), .b(b_in[7:0]), .bin(bin), .out_valid(out_valid_v[2]), .out_ready(out_ready),
    .diff(d2), .bout(bout_v[2]), .ovf(ovf_v[2]), .busy(busy_v[2]));
  serial_subtractor #(.WIDTH(8), .DIGIT(8)) u_8d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[3]),
    .a(a_in[7:0]), .b(b_in[7:0]), .bin(bin), .out_valid(out_valid_v[3]), .out_ready(out_ready),
    .diff(d3), .bout(bout_v[3]), .ovf(ovf_v[3]), .busy(busy_v[3]));
  serial_subtractor #(.WIDTH(16), .DIGIT(1)) u_16d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[4]),
    .a(a_in), .b(b_in), .bin(bin), .out_valid(out_valid_v[4]), .out_ready(out_ready),
    .diff(d4), .bout(bout_v[4]), .ovf(ovf_v[4]), .busy(busy_v[4]));
  serial_subtractor #(.WIDTH(16), .DIGIT(2)) u_16d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[5]),
    .a(a_in), .b(b_in), .bin(bin), .out_valid(out_valid_v[5]), .out_ready(out_ready),
    .diff(d5), .bout(bout_v[5]), .ovf(ovf_v[5]), .busy(busy_v[5]));
  serial_subtractor #(.WIDTH(16), .DIGIT(4)) u_16d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[6]),
    .a(a_in), .b(b_in), .bin(bin), .out_valid(out_valid_v[6]), .out_ready(out_ready),
    .diff(d6), .bout(bout_v[6]), .ovf(ovf_v[6]), .busy(busy_v[6]));

  always_comb begin
    diff_v[0] = {8'h00, d0};
    diff_v[1] = {8'h00, d1};
    diff_v[2] = {8'h00, d2};
    diff_v[3] = {8'h00, d3};
    diff_v[4] = d4;
    diff_v[5] = d5;
    diff_v[6] = d6;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Integer reference: unsigned borrow from a - b - bin, signed range test for overflow
  function automatic void model(input int w, input logic [15:0] a, input logic [15:0] b, input logic bi,
                                output logic [15:0] d, output logic bo, output logic ov);
    int ua, ub, sa, sb, r, s, m;
    m  = (1 << w) - 1;
    ua = int'(a) & m;
    ub = int'(b) & m;
    r  = ua - ub - int'(bi);
    bo = (r < 0);
    d  = 16'(r & m);
    sa = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
    sb = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
    s  = sa - sb - int'(bi);
    ov = (s < -(1 << (w - 1))) || (s > (1 << (w - 1)) - 1);
  endfunction

  task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic bi);
    @(negedge clk);
    chk("launch_in_ready", in_ready_v, 7'h7F);
    a_in = a; b_in = b; bin = bi; in_valid = 1'b1;
    cur_a = a; cur_b = b; cur_bin = bi;
    @(negedge clk);
    in_valid = 1'b0;
    chk("accept_busy", busy_v, 7'h7F);
  endtask

  // Starts at the negedge right after acceptance; drains every instance
  task automatic finish_op(input bit stall);
    int          j;
    bit   [6:0]  done;
    bit   [6:0]  seen;
    int          bcnt [7];
    logic [15:0] ed;
    logic        eb, eo;
    done = '0; seen = '0; j = 0;
    for (int i = 0; i < 7; i++) bcnt[i] = 0;
    while (done != 7'h7F && j < 300) begin
      for (int i = 0; i < 7; i++) if (busy_v[i]) bcnt[i]++;
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int i = 0; i < 7; i++) begin
        if (!done[i] && out_valid_v[i]) begin
          if (!seen[i]) begin
            seen[i] = 1'b1;
            model(WID[i], cur_a, cur_b, cur_bin, ed, eb, eo);
            chk("latency", j, NST[i]);
            chk("diff", diff_v[i], ed);
            chk("bout", bout_v[i], eb);
            chk("ovf", ovf_v[i], eo);
            cap_diff[i] = diff_v[i]; cap_bout[i] = bout_v[i]; cap_ovf[i] = ovf_v[i];
          end else begin
            chk("stall_diff_hold", diff_v[i], cap_diff[i]);
            chk("stall_flag_hold", {bout_v[i], ovf_v[i]}, {cap_bout[i], cap_ovf[i]});
          end
          if (out_ready) done[i] = 1'b1;
        end
      end
      @(negedge clk);
      j++;
    end
    chk("drain_timeout", done, 7'h7F);
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) chk("busy_cycles", bcnt[i], NST[i]);
    chk("post_out_valid", out_valid_v, 7'h00);
    chk("post_in_ready", in_ready_v, 7'h7F);
  endtask

  initial begin
    int j;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; bin = 1'b0; a_in = '0; b_in = '0;
    cur_a = '0; cur_b = '0; cur_bin = 1'b0;
    #12;
    chk("rst_in_ready", in_ready_v, 7'h7F);
    chk("rst_out_valid", out_valid_v, 7'h00);
    chk("rst_busy", busy_v, 7'h00);
    chk("rst_flags", {bout_v, ovf_v}, 14'h0);
    chk("rst_diff16", diff_v[4], 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic subtraction with latency and busy duration
    launch(16'h0005, 16'h0003, 1'b0);
    finish_op(1'b0);
    chk("t1_diff", cap_diff[0], 16'h0002);
    chk("t1_bout_ovf", {cap_bout[0], cap_ovf[0]}, 2'b00);

    // Unsigned wrap, then signed overflow with borrow-in
    launch(16'h0000, 16'h0001, 1'b0);
    finish_op(1'b1);
    chk("t2a_diff", cap_diff[0], 16'h00FF);
    chk("t2a_bout_ovf", {cap_bout[0], cap_ovf[0]}, 2'b10);
    launch(16'h0080, 16'h0000, 1'b1);
    finish_op(1'b1);
    chk("t2b_diff", cap_diff[0], 16'h007F);
    chk("t2b_bout_ovf", {cap_bout[0], cap_ovf[0]}, 2'b01);

    // Both flags at once on the wide-digit configurations
    launch(16'h007F, 16'h00FF, 1'b0);
    finish_op(1'b0);
    chk("t3_d4_diff", cap_diff[2], 16'h0080);
    chk("t3_d4_flags", {cap_bout[2], cap_ovf[2]}, 2'b11);
    chk("t3_d8_diff", cap_diff[3], 16'h0080);
    chk("t3_d8_flags", {cap_bout[3], cap_ovf[3]}, 2'b11);

    // Backpressure with new operands waiting on in_valid
    launch(16'h0033, 16'h0011, 1'b0);
    out_ready = 1'b0;
    j = 0;
    while (out_valid_v != 7'h7F && j < 40) begin
      @(negedge clk);
      j++;
    end
    chk("bp_all_valid", out_valid_v, 7'h7F);
    a_in = 16'h0044; b_in = 16'h0022; bin = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid_v, 7'h7F);
      chk("bp_in_ready", in_ready_v, 7'h00);
      chk("bp_diff8", diff_v[0], 16'h0022);
      chk("bp_diff16", diff_v[4], 16'h0022);
      chk("bp_flags", {bout_v, ovf_v}, 14'h0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_idle_ready", in_ready_v, 7'h7F);
    chk("bp_idle_ovalid", out_valid_v, 7'h00);
    chk("bp_diff_kept", diff_v[0], 16'h0022);
    cur_a = 16'h0044; cur_b = 16'h0022; cur_bin = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_accept_first_idle", busy_v, 7'h7F);
    finish_op(1'b0);
    chk("bp_second_diff", cap_diff[0], 16'h0021);

    // Asynchronous reset mid-operation, then a clean operation
    launch(16'h00A5, 16'h005A, 1'b0);
    @(negedge clk); @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready_v, 7'h7F);
    chk("mid_rst_out_valid", out_valid_v, 7'h00);
    chk("mid_rst_busy", busy_v, 7'h00);
    chk("mid_rst_flags", {bout_v, ovf_v}, 14'h0);
    chk("mid_rst_diff8", diff_v[3], 16'h0000);
    chk("mid_rst_diff16", diff_v[6], 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    launch(16'h0010, 16'h0010, 1'b1);
    finish_op(1'b0);
    chk("t5_diff", cap_diff[0], 16'h00FF);
    chk("t5_bout_ovf", {cap_bout[0], cap_ovf[0]}, 2'b10);
    chk("t5_diff16", cap_diff[4], 16'hFFFF);

    // Random sweep with random stalls
    for (int n = 0; n < 1000; n++) begin
      launch(16'($urandom()), 16'($urandom()), 1'($urandom_range(0, 1)));
      finish_op(1'b1);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
